// File: rtl/key_press_classifier.sv
// key_press_classifier
//   Synchronises and debounces one active-low push-button and classifies each
//   press into one-cycle event pulses for the watch mode FSM and counters.
//
//   Parameters
//     IN_CLK_HZ    clock frequency in Hz; one millisecond = IN_CLK_HZ/1000 cycles
//     DEBOUNCE_MS  stable time needed to accept a press or a release
//     LONG_MS      hold time before key_long fires
//     REPEAT_MS    auto-repeat period once key_long has fired
//
//   Ports
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     key_n       raw button input, asynchronous, 0 = pressed
//     key_first   pulse on an accepted press
//     key_short   pulse on an accepted release when key_long did not fire
//     key_long    pulse once per press after LONG_MS of hold
//     key_repeat  pulse every REPEAT_MS while still held after key_long
//     key_level   debounced pressed level
module key_press_classifier #(
  parameter int IN_CLK_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_first,
  output logic key_short,
  output logic key_long,
  output logic key_repeat,
  output logic key_level
);

  localparam int MS_CYC  = (IN_CLK_HZ / 1000 < 1) ? 1 : IN_CLK_HZ / 1000;
  localparam int DEB_CYC = DEBOUNCE_MS * MS_CYC;
  localparam int LONG_CYC = LONG_MS * MS_CYC;
  localparam int REP_CYC = REPEAT_MS * MS_CYC;

  localparam int MAX_A   = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
  localparam int MAX_B   = (MAX_A > REP_CYC) ? MAX_A : REP_CYC;
  localparam int MAX_CYC = (MAX_B < 1) ? 1 : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Each counter starts at 0 on entry to its state, so the terminal value is
  // one less than the cycle count (a zero count behaves like a count of one).
  localparam logic [CW-1:0] DEB_LIM  = CW'((DEB_CYC  < 1) ? 0 : DEB_CYC  - 1);
  localparam logic [CW-1:0] LONG_LIM = CW'((LONG_CYC < 1) ? 0 : LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LIM  = CW'((REP_CYC  < 1) ? 0 : REP_CYC  - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    HELD,
    DB_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, key_s;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] rep_q, rep_d;
  logic          orig_held_q, orig_held_d;
  logic          first_d, short_d, long_d, repeat_d, level_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Two-flop synchroniser on the inverted input: key_s = 1 means pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      key_s   <= 1'b0;
    end else begin
      sync1_q <= ~key_n;
      key_s   <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      orig_held_q <= 1'b0;
      key_first   <= 1'b0;
      key_short   <= 1'b0;
      key_long    <= 1'b0;
      key_repeat  <= 1'b0;
      key_level   <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      orig_held_q <= orig_held_d;
      key_first   <= first_d;
      key_short   <= short_d;
      key_long    <= long_d;
      key_repeat  <= repeat_d;
      key_level   <= level_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    rep_d       = rep_q;
    orig_held_d = orig_held_q;
    first_d     = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = DB_PRESS;
          deb_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!key_s) begin
          state_d = IDLE;
        end else if (deb_q >= DEB_LIM) begin
          state_d = PRESSED;
          first_d = 1'b1;
          hold_d  = '0;
        end else begin
          deb_d = sat_inc(deb_q);
        end
      end

      // The hold/repeat count advances on every cycle spent in its state,
      // including the cycle that leaves for DB_RELEASE; it is frozen only
      // while actually in DB_RELEASE. A glitch of N cycles therefore delays
      // the next event by exactly N cycles.
      PRESSED: begin
        hold_d = sat_inc(hold_q);
        if (!key_s) begin
          state_d     = DB_RELEASE;
          orig_held_d = 1'b0;
          deb_d       = '0;
        end else if (hold_q >= LONG_LIM) begin
          state_d = HELD;
          long_d  = 1'b1;
          rep_d   = '0;
        end
      end

      HELD: begin
        rep_d = sat_inc(rep_q);
        if (!key_s) begin
          state_d     = DB_RELEASE;
          orig_held_d = 1'b1;
          deb_d       = '0;
        end else if (rep_q >= REP_LIM) begin
          repeat_d = 1'b1;
          rep_d    = '0;
        end
      end

      DB_RELEASE: begin
        if (key_s) begin
          state_d = orig_held_q ? HELD : PRESSED;
        end else if (deb_q >= DEB_LIM) begin
          state_d = IDLE;
          short_d = ~orig_held_q;
        end else begin
          deb_d = sat_inc(deb_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    level_d = (state_d == PRESSED) || (state_d == HELD) || (state_d == DB_RELEASE);
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier
//   Directed bench for key_press_classifier with 1 ms = 1 cycle,
//   DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5. Each case loads a key_n pattern
//   and hand-computed expected pulse cycles, then compares every output on
//   every cycle, sampled 1 time unit after the rising edge.
module tb_key_press_classifier;

  logic clk = 1'b0;
  logic rst_n;
  logic key_n;
  logic key_first, key_short, key_long, key_repeat, key_level;

  int checks = 0;
  int errors = 0;

  localparam int N = 128;
  logic kpat [N];
  logic ef   [N];
  logic es   [N];
  logic el   [N];
  logic er   [N];
  logic elev [N];

  key_press_classifier #(
    .IN_CLK_HZ  (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20),
    .REPEAT_MS  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (key_n),
    .key_first (key_first),
    .key_short (key_short),
    .key_long  (key_long),
    .key_repeat(key_repeat),
    .key_level (key_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %b expected %b", tag, c, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c,
                         input logic f, input logic s, input logic l,
                         input logic r, input logic v);
    chk({tag, ".first"},  c, key_first,  f);
    chk({tag, ".short"},  c, key_short,  s);
    chk({tag, ".long"},   c, key_long,   l);
    chk({tag, ".repeat"}, c, key_repeat, r);
    chk({tag, ".level"},  c, key_level,  v);
  endtask

  task automatic clear_case();
    for (int i = 0; i < N; i++) begin
      kpat[i] = 1'b1;
      ef[i]   = 1'b0;
      es[i]   = 1'b0;
      el[i]   = 1'b0;
      er[i]   = 1'b0;
      elev[i] = 1'b0;
    end
  endtask

  task automatic press(input int a, input int b);
    for (int i = a; i <= b; i++) kpat[i] = 1'b0;
  endtask

  task automatic level(input int a, input int b);
    for (int i = a; i <= b; i++) elev[i] = 1'b1;
  endtask

  // Cycle c: key_n = kpat[c] is sampled at edge c; outputs checked after it.
  // If rst_at >= 0, rst_n drops just before edge rst_at and rises after it.
  task automatic run_case(input string tag, input int ncyc, input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      key_n = kpat[c];
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_all({tag, ".rst_async"}, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk);
      #1;
      if (c == rst_at) rst_n = 1'b1;
      chk_all(tag, c, ef[c], es[c], el[c], er[c], elev[c]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b0;

    // Reset held with the key pressed: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all("reset", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    // Key still down from reset, released at 15.
    clear_case();
    press(0, 14);
    ef[6] = 1'b1; es[21] = 1'b1; level(6, 20);
    run_case("post_reset", 28, -1);

    // Short press.
    clear_case();
    press(0, 9);
    ef[6] = 1'b1; es[16] = 1'b1; level(6, 15);
    run_case("short", 24, -1);

    // 4 low cycles: one short of acceptance.
    clear_case();
    press(0, 3);
    run_case("min_reject", 12, -1);

    // 5 low cycles: shortest accepted press.
    clear_case();
    press(0, 4);
    ef[6] = 1'b1; es[11] = 1'b1; level(6, 10);
    run_case("min_accept", 16, -1);

    // Bounce: 3 low, 2 high, five times.
    clear_case();
    for (int k = 0; k < 5; k++) press(5 * k, 5 * k + 2);
    run_case("bounce", 34, -1);

    // Long hold with auto-repeat.
    clear_case();
    press(0, 39);
    ef[6] = 1'b1; el[26] = 1'b1;
    er[31] = 1'b1; er[36] = 1'b1; er[41] = 1'b1;
    level(6, 45);
    run_case("long", 52, -1);

    // Release glitch of 2 cycles delays key_long by 2; released at 30.
    clear_case();
    press(0, 29);
    kpat[12] = 1'b1; kpat[13] = 1'b1;
    ef[6] = 1'b1; el[28] = 1'b1; level(6, 35);
    run_case("glitch", 42, -1);

    // Reset pulse at cycle 30 during a long hold; key held until 63.
    clear_case();
    press(0, 63);
    ef[6] = 1'b1; el[26] = 1'b1; level(6, 29);
    ef[37] = 1'b1; el[57] = 1'b1; er[62] = 1'b1; level(37, 69);
    run_case("mid_reset", 78, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_press_classifier.md
# key_press_classifier

Per-button front end for the watch top level. It synchronises and debounces one active-low push-button and turns each press into one-cycle event pulses: press, short release, long hold and auto-repeat. The pulses feed the mode state machine and the watch/stopwatch counters directly. One instance is used per button.

## Interface
- IN_CLK_HZ, 50_000_000, clock frequency; defines the 1 ms tick (MS_CYC = IN_CLK_HZ/1000, minimum 1)
- DEBOUNCE_MS, 10, stable time required to accept a press or release; DEB_CYC = DEBOUNCE_MS*MS_CYC
- LONG_MS, 1000, hold time before key_long fires; LONG_CYC = LONG_MS*MS_CYC
- REPEAT_MS, 200, auto-repeat period after key_long; REP_CYC = REPEAT_MS*MS_CYC
- clk  input  1  system clock; all logic is rising-edge
- rst_n  input  1  asynchronous, active-low reset
- key_n  input  1  raw button, asynchronous; 0 = pressed
- key_first  output  1  one-cycle pulse on an accepted press
- key_short  output  1  one-cycle pulse on an accepted release when key_long did not fire
- key_long  output  1  one-cycle pulse once per press after LONG_CYC of hold
- key_repeat  output  1  one-cycle pulse every REP_CYC while the button is still held after key_long
- key_level  output  1  debounced pressed level

## Operation
- Synchroniser: two flops on ~key_n produce key_s (1 = pressed). Both flops reset to 0 (released).
- All outputs are registered. Every pulse is high for exactly one cycle.
- Counters are sized $clog2(max(DEB_CYC, LONG_CYC, REP_CYC)+1). Counters saturate and never wrap.
- The FSM has five states. Reset state is IDLE.
  - IDLE: key_s=1 -> DB_PRESS, debounce count cleared.
  - DB_PRESS: key_s=0 -> IDLE with no output. When key_s has been 1 for DEB_CYC consecutive cycles -> PRESSED, key_first=1, hold count cleared.
  - PRESSED: the hold count increments each cycle. Reaching LONG_CYC -> HELD, key_long=1, repeat count cleared. key_s=0 -> DB_RELEASE with origin=PRESSED.
  - HELD: the repeat count increments each cycle. Reaching REP_CYC -> key_repeat=1, count cleared. key_s=0 -> DB_RELEASE with origin=HELD.
  - DB_RELEASE: key_s=1 before the release is confirmed -> return to origin. When key_s has been 0 for DEB_CYC consecutive cycles -> IDLE, and key_short=1 if origin=PRESSED.
- Hold and repeat counters freeze while in DB_RELEASE and resume on return to origin, so a release glitch delays key_long and key_repeat by the glitch length.
- key_level is 1 in PRESSED, HELD and DB_RELEASE, and 0 otherwise.
- Within one press:
  - key_first precedes key_long, which precedes any key_repeat.
  - key_short and key_long are mutually exclusive.
  - Only one event fires per cycle.

## Timing
- Reset: every output is 0 while rst_n=0 and on the first edge after deassertion. The FSM is in IDLE and all counters are 0.
- Press latency: key_n is first sampled low at edge 0. If it stays low, key_first is high after edge DEB_CYC+2.
- key_long is high LONG_CYC cycles after key_first.
- The first key_repeat is REP_CYC cycles after key_long, then one every REP_CYC cycles.
- Release latency: key_n is sampled high at edge R. If it stays high, key_short (if due) is high after edge R+DEB_CYC+2, and key_level falls on the same edge.
- Reset mid-operation: the FSM aborts immediately with no pulses. If the button is still held after reset, it is treated as a new press: key_first fires again after DEB_CYC+2 cycles.
- A press/release glitch shorter than DEB_CYC produces no event and no key_level change.

## Test plan
Bench overrides: IN_CLK_HZ=1000 (1 ms = 1 cycle), DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5.
- Reset: hold rst_n=0 with key_n=0 -> all outputs 0. After release of reset -> key_first at cycle 6, not earlier.
- Short press: key_n=0 for cycles 0-9 -> key_first at 6. key_short at 16 (release at 10, plus 6). key_level high over cycles 6-15. No key_long.
- Bounce: key_n low for 3 cycles, high for 2, repeated 5 times -> no pulses, key_level stays 0.
- Long hold: key_n=0 for cycles 0-39 -> key_first at 6, key_long at 26, key_repeat at 31, 36 and 41 only. key_level falls at 46. No key_short.
- Release glitch: key_n=0 from cycle 0, with a 2-cycle high glitch at cycle 12 -> key_level stays 1, no key_short, key_long at 28.
- Reset mid-hold: rst_n pulsed low at cycle 30 during the long hold -> outputs 0 immediately. With the key still held, key_first fires 6 cycles after reset release and key_long 20 cycles after that.
